// File: rtl/instr_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// The queue entry is the PC/instruction/fault triple handed to decode.
package instr_prefetch_queue_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;
  localparam int ENTRY_W = PC_W + INSTR_W + 1;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               inv_addr;
  } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head read.
// Clear empties the FIFO first, then a same-cycle push lands in slot 0.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW-1:0]    wr_addr;
  logic             do_push, do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign count    = count_reg;
  assign pop_data = mem[rd_ptr_reg];

  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (clear | ~full | do_pop);
  assign wr_addr = clear ? '0 : wr_ptr_reg;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_addr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= do_push ? AW'(1) : '0;
      count_reg  <= do_push ? (AW+1)'(1) : '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch front end: credit-limited in-order requests to instruction memory,
// response buffering with PCs, and redirect flush with in-flight drop.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_invAddr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t      state_reg, state_next;
  logic [63:0] fetch_pc_reg, fetch_pc_next;
  logic [63:0] pc_tag_reg, pc_tag_next;
  logic [CW-1:0] in_flight_reg, in_flight_next;
  logic [CW-1:0] drop_cnt_reg, drop_cnt_next;

  logic          fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  entry_t        push_entry, head;
  logic [CW:0]   occ_sum;
  logic          credit_ok, req_fire, rsp_counted, rsp_keep;
  logic          redirect_act, redirect_misaligned;

  assign redirect_act        = redirect_valid & (state_reg != S_IDLE);
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

  // Queued entries plus outstanding requests never exceed the queue depth.
  assign occ_sum   = {1'b0, fifo_count} + {1'b0, in_flight_reg};
  assign credit_ok = (occ_sum < (CW+1)'(DEPTH));

  assign imem_req_valid = (state_reg == S_FETCH) & credit_ok & ~redirect_valid;
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_counted = imem_rsp_valid & (in_flight_reg != '0);
  assign rsp_keep    = rsp_counted & (drop_cnt_reg == '0) & ~redirect_act;

  always_comb begin
    push_entry = '{pc: pc_tag_reg, instr: imem_rsp_data, inv_addr: imem_rsp_err};
    if (redirect_act) push_entry = '{pc: redirect_pc, instr: 32'h0, inv_addr: 1'b1};
  end

  assign fifo_clear = redirect_act;
  assign fifo_push  = rsp_keep | (redirect_act & redirect_misaligned);
  assign fifo_pop   = out_valid & out_ready & ~redirect_act;

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid   = ~fifo_empty;
  assign out_pc      = out_valid ? head.pc : '0;
  assign out_instr   = out_valid ? head.instr : '0;
  assign out_invAddr = out_valid & head.inv_addr;
  assign busy        = (in_flight_reg != '0);

  always_comb begin
    state_next     = state_reg;
    fetch_pc_next  = fetch_pc_reg;
    pc_tag_next    = pc_tag_reg;
    in_flight_next = in_flight_reg + CW'(req_fire) - CW'(rsp_counted);
    drop_cnt_next  = drop_cnt_reg;

    if (redirect_act) begin
      // Everything still outstanding belongs to the abandoned path.
      drop_cnt_next = in_flight_reg - CW'(rsp_counted);
      fetch_pc_next = redirect_pc;
      pc_tag_next   = redirect_pc;
    end else begin
      if (rsp_counted && drop_cnt_reg != '0) drop_cnt_next = drop_cnt_reg - 1'b1;
      if (req_fire) fetch_pc_next = fetch_pc_reg + 64'd4;
      if (rsp_keep) pc_tag_next = pc_tag_reg + 64'd4;
    end

    case (state_reg)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: begin
        if (redirect_act && redirect_misaligned) state_next = S_HALT;
        else if (rsp_keep && imem_rsp_err)       state_next = S_HALT;
      end
      S_HALT: begin
        if (redirect_act && !redirect_misaligned) state_next = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      fetch_pc_reg  <= RESET_PC;
      pc_tag_reg    <= RESET_PC;
      in_flight_reg <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      assert (!(fifo_push && fifo_full && !fifo_clear));
      state_reg     <= state_next;
      fetch_pc_reg  <= fetch_pc_next;
      pc_tag_reg    <= pc_tag_next;
      in_flight_reg <= in_flight_next;
      drop_cnt_reg  <= drop_cnt_next;
    end
  end

endmodule
